alu_result_tx: RTL and testbench



---
 rtl/alu_result_tx.sv | 135 +++++++++++++
 tb/tb_alu_result_tx.sv | 152 +++++++++++++++
 2 files changed

// File: rtl/alu_result_tx.sv
// Serial UART-style transmitter for an ALU result plus its four status flags.
// Define ALU_TX_PARITY_EN to insert an even-parity bit before the stop bit.
module alu_result_tx #(
    parameter int CLKS_PER_BIT = 10
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] resultado,
    input  logic [3:0] flags,
    input  logic       start,
    output logic       tx,
    output logic       busy,
    output logic       done
);

    localparam int TW = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [TW-1:0] LAST = TW'(CLKS_PER_BIT - 1);

`ifdef ALU_TX_PARITY_EN
    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } state_t;
    logic par;
`else
    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        STOP
    } state_t;
`endif

    state_t        state;
    logic [TW-1:0] timer;
    logic [3:0]    idx;
    logic [11:0]   shreg;
    logic          bit_end;

    assign bit_end = (timer == LAST);

    // tx is always loaded one edge ahead with the level of the bit being entered
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            timer <= '0;
            idx   <= '0;
            shreg <= '0;
            tx    <= 1'b1;
            busy  <= 1'b0;
            done  <= 1'b0;
`ifdef ALU_TX_PARITY_EN
            par   <= 1'b0;
`endif
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    timer <= '0;
                    idx   <= '0;
                    if (start) begin
                        state <= START;
                        shreg <= {flags, resultado};
                        tx    <= 1'b0;
                        busy  <= 1'b1;
`ifdef ALU_TX_PARITY_EN
                        par   <= ^{flags, resultado};
`endif
                    end
                end
                START: begin
                    if (bit_end) begin
                        state <= DATA;
                        timer <= '0;
                        tx    <= shreg[0];
                    end else begin
                        timer <= timer + 1'b1;
                    end
                end
                DATA: begin
                    if (bit_end) begin
                        timer <= '0;
                        if (idx == 4'd11) begin
`ifdef ALU_TX_PARITY_EN
                            state <= PARITY;
                            tx    <= par;
`else
                            state <= STOP;
                            tx    <= 1'b1;
`endif
                        end else begin
                            idx   <= idx + 4'd1;
                            shreg <= shreg >> 1;
                            tx    <= shreg[1];
                        end
                    end else begin
                        timer <= timer + 1'b1;
                    end
                end
`ifdef ALU_TX_PARITY_EN
                PARITY: begin
                    if (bit_end) begin
                        state <= STOP;
                        timer <= '0;
                        tx    <= 1'b1;
                    end else begin
                        timer <= timer + 1'b1;
                    end
                end
`endif
                STOP: begin
                    if (bit_end) begin
                        state <= IDLE;
                        timer <= '0;
                        idx   <= '0;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                    end else begin
                        timer <= timer + 1'b1;
                    end
                end
                default: begin
                    state <= IDLE;
                    timer <= '0;
                    tx    <= 1'b1;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_alu_result_tx.sv
// Directed and randomized bench for alu_result_tx at 4 clocks per bit.
// The expected frame is built from the payload with plain bit arithmetic.
module tb_alu_result_tx;

    localparam int C = 4;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       start = 1'b0;
    logic [7:0] resultado = '0;
    logic [3:0] flags = '0;
    logic       tx;
    logic       busy;
    logic       done;

    int total = 0;
    int bad = 0;
    logic exp_q[$];

    alu_result_tx #(.CLKS_PER_BIT(C)) dut (
        .clk(clk),
        .rst_n(rst_n),
        .resultado(resultado),
        .flags(flags),
        .start(start),
        .tx(tx),
        .busy(busy),
        .done(done)
    );

    always #5 clk = ~clk;

    function automatic void build(input logic [7:0] r, input logic [3:0] f);
        logic [11:0] p;
        int ones;
        ones = 0;
        p = {f, r};
        exp_q.delete();
        exp_q.push_back(1'b0);
        for (int i = 0; i < 12; i++) begin
            exp_q.push_back(p[i]);
            ones += int'(p[i]);
        end
`ifdef ALU_TX_PARITY_EN
        exp_q.push_back((ones % 2) == 1);
`endif
        exp_q.push_back(1'b1);
    endfunction

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] expv);
        total++;
        assert (obs === expv) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    task automatic idle_check(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            check("idle", {29'd0, tx, busy, done}, 32'b100);
        end
    endtask

    task automatic run_frame(input logic [7:0] r, input logic [3:0] f,
                             input bit hold, input bit poke);
        int nb;
        build(r, f);
        nb = exp_q.size();
        resultado = r;
        flags = f;
        start = 1'b1;
        for (int c = 0; c <= nb * C; c++) begin
            @(negedge clk);
            if (!hold) start = 1'b0;
            if (poke && c == 10) begin
                resultado = 8'hFF;
                flags = 4'hF;
                start = 1'b1;
            end
            if (c == 0) check("tx_fall", {31'd0, tx}, 32'd0);
            if (c < nb * C && c % C == C / 2) begin
                check($sformatf("bit%0d", c / C), {31'd0, tx},
                      {31'd0, exp_q[c / C]});
                check("busy", {31'd0, busy}, 32'd1);
            end
            if (c == nb * C - 1) check("done_early", {31'd0, done}, 32'd0);
            if (c == nb * C) begin
                check("done", {31'd0, done}, 32'd1);
                check("busy_end", {31'd0, busy}, 32'd0);
                check("tx_end", {31'd0, tx}, 32'd1);
            end
        end
    endtask

    initial begin
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        idle_check(3);

        // asynchronous reset between edges
        #2 rst_n = 1'b0;
        #1 check("rst_out", {29'd0, tx, busy, done}, 32'b100);
        @(negedge clk);
        rst_n = 1'b1;
        idle_check(100);

        run_frame(8'hA5, 4'b1001, 1'b0, 1'b0);
        idle_check(3);
        run_frame(8'h01, 4'b0000, 1'b0, 1'b0);
        idle_check(2);

        repeat (6) begin
            run_frame(8'($urandom), 4'($urandom), 1'b0, 1'b0);
            idle_check($urandom_range(0, 5));
        end

        // start during a frame is ignored and inputs are snapshotted
        run_frame(8'h00, 4'h0, 1'b0, 1'b1);
        resultado = 8'h00;
        flags = 4'h0;
        idle_check(20);

        // held start: back-to-back frames, fresh snapshot each time
        run_frame(8'h3C, 4'h0, 1'b1, 1'b0);
        run_frame(8'h3C, 4'h0, 1'b1, 1'b0);
        run_frame(8'($urandom), 4'($urandom), 1'b0, 1'b0);
        idle_check(5);

        // reset during data bit 5
        build(8'h5A, 4'h6);
        resultado = 8'h5A;
        flags = 4'h6;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int c = 1; c <= 6 * C + C / 2; c++) @(negedge clk);
        check("pre_rst_bit5", {31'd0, tx}, {31'd0, exp_q[6]});
        #2 rst_n = 1'b0;
        #1 check("mid_rst", {29'd0, tx, busy, done}, 32'b100);
        @(negedge clk);
        rst_n = 1'b1;
        idle_check(15 * C + 10);
        run_frame(8'($urandom), 4'($urandom), 1'b0, 1'b0);
        idle_check(3);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
